// File: rtl/mux.sv
// Registered 2:1 multiplexer.
//
// A combinational select stage drives the internal node aux. aux is
// captured into the output register on every rising clk edge, so out
// only ever changes on a clock edge or on asynchronous reset. Glitches
// on aux between edges never reach out.
//
// Optional build macro: MUX_SEL_SYNC_EN
//   Defined   : sel passes through a 2-flop synchronizer (sel_s1, sel_s2)
//               clocked by clk and cleared by rst_n. sel_s2 is the
//               effective select. Select-to-out latency is 3 edges;
//               data-to-out latency stays 1 edge.
//   Undefined : sel drives the select stage directly (1 edge latency).
//
// Handshake: none. Every rising clk edge with rst_n high loads aux into
// out unconditionally; there is no valid/ready qualification.

module mux #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  // Effective select seen by the combinational stage.
  logic             sel_eff;

  // Combinational mux result; kept as a named net for debug probing.
  logic [WIDTH-1:0] aux;

`ifdef MUX_SEL_SYNC_EN
  logic sel_s1;
  logic sel_s2;

  // Two-flop synchronizer for an asynchronous select source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_s1 <= 1'b0;
      sel_s2 <= 1'b0;
    end else begin
      sel_s1 <= sel;
      sel_s2 <= sel_s1;
    end
  end

  assign sel_eff = sel_s2;
`else
  assign sel_eff = sel;
`endif

  // Select stage: the conditional operator merges in1/in2 bitwise when
  // sel_eff is X/Z in simulation.
  assign aux = sel_eff ? in2 : in1;

  // Output register: async clear to RESET_VALUE, otherwise capture aux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= RESET_VALUE;
    end else begin
      out <= aux;
    end
  end

endmodule

// File: tb/tb_mux.sv
// Testbench for mux (WIDTH=8, default RESET_VALUE).
// Expected out values come from a reference model of the select path
// (including the optional synchronizer when MUX_SEL_SYNC_EN is defined),
// pushed to exp_q at each rising edge and popped after the edge.

module tb_mux;

  localparam int         W  = 8;
  localparam logic [W-1:0] RV = '0;

  // ---------------------------------------------------------------
  // Clock / reset block: period 20 ns, first rising edge at 15 ns.
  // ---------------------------------------------------------------
  logic         clk;
  logic         rst_n;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         sel;
  logic [W-1:0] out;

  initial begin
    clk = 1'b0;
    #15 clk = 1'b1;
    forever #10 clk = ~clk;
  end

  mux #(
    .WIDTH      (W),
    .RESET_VALUE(RV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (in1),
    .in2  (in2),
    .sel  (sel),
    .out  (out)
  );

  // ---------------------------------------------------------------
  // Scoreboard state and reference model of the select path.
  // ---------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           n_cmp;
  int           n_err;
  logic         m_s1;
  logic         m_s2;

  // Model synchronizer clears asynchronously with the DUT.
  always @(negedge rst_n) begin
    m_s1 = 1'b0;
    m_s2 = 1'b0;
  end

  function automatic logic model_sel_eff();
`ifdef MUX_SEL_SYNC_EN
    return m_s2;
`else
    return sel;
`endif
  endfunction

  function automatic logic [W-1:0] model_aux();
    return model_sel_eff() ? in2 : in1;
  endfunction

  // Driver: wait for the rising edge, push the value out must take,
  // advance the model, and return 1 ns after the edge.
  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    if (!rst_n) e = RV;
    else        e = model_aux();
    exp_q.push_back(e);
`ifdef MUX_SEL_SYNC_EN
    if (rst_n) begin
      m_s2 = m_s1;
      m_s1 = sel;
    end
`endif
    #1;
  endtask

  // ---------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------
  task automatic test_reset();
    logic [W-1:0] e;
    in1 = 8'h00; in2 = 8'h01; sel = 1'b1;
    #5 rst_n = 1'b0;          // between edges, before first posedge
    #1;
    n_cmp++;
    if (out !== RV) begin
      n_err++;
      $display("FAIL reset_immediate: out=%h expected=%h", out, RV);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: out=%h expected=%h", i, out, e);
      end
    end
    #4 rst_n = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (out !== e) begin
      n_err++;
      $display("FAIL reset_release: out=%h expected=%h", out, e);
    end
  endtask

  task automatic test_static_in1();
    logic [W-1:0] e;
    sel = 1'b0; in1 = 8'h00; in2 = 8'h01;
    // Let a synchronized select settle to 0 if the synchronizer is built.
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e) begin
        n_err++;
        $display("FAIL static_in1_zero[%0d]: out=%h expected=%h", i, out, e);
      end
    end
    n_cmp++;
    if (dut.aux !== 8'h00) begin
      n_err++;
      $display("FAIL static_in1_aux: aux=%h expected=%h", dut.aux, 8'h00);
    end
    in1 = 8'h01; in2 = 8'h00;
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (out !== e || out !== 8'h01) begin
      n_err++;
      $display("FAIL static_in1_swap: out=%h expected=%h", out, e);
    end
  endtask

  task automatic test_alternating();
    logic [W-1:0] e;
    @(posedge clk);
    #5;                        // local t=0, 15 ns before the next edge
    sel = 1'b0; in1 = 8'h00; in2 = 8'h01;
    for (int k = 0; k < 6; k++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e) begin
        n_err++;
        $display("FAIL alternating[t=%0d]: out=%h expected=%h", 15 + 20 * k, out, e);
      end
      #4;                      // local t = 20*(k+1)
      sel = ~sel;
      if (k + 1 == 5) begin
        in1 = 8'h01; in2 = 8'h00;
      end
    end
  endtask

  task automatic test_glitch();
    logic [W-1:0] e;
    logic [W-1:0] ea;
    sel = 1'b0; in1 = 8'h00; in2 = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      void'(exp_q.pop_front());
    end
    #3 sel = 1'b1;
    #1;
    ea = model_aux();
    n_cmp++;
    if (dut.aux !== ea) begin
      n_err++;
      $display("FAIL glitch_aux_high: aux=%h expected=%h", dut.aux, ea);
    end
    #3 sel = 1'b0;
    #1;
    ea = model_aux();
    n_cmp++;
    if (dut.aux !== ea) begin
      n_err++;
      $display("FAIL glitch_aux_low: aux=%h expected=%h", dut.aux, ea);
    end
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (out !== e || out !== 8'h00) begin
      n_err++;
      $display("FAIL glitch_out: out=%h expected=%h", out, e);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    sel = 1'b0; in1 = 8'h01; in2 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
    end
    n_cmp++;
    if (out !== e || out !== 8'h01) begin
      n_err++;
      $display("FAIL async_pre: out=%h expected=%h", out, 8'h01);
    end
    #6 rst_n = 1'b0;           // 7 ns after the posedge
    #1;
    n_cmp++;
    if (out !== RV) begin
      n_err++;
      $display("FAIL async_mid_cycle: out=%h expected=%h", out, RV);
    end
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (out !== e) begin
      n_err++;
      $display("FAIL async_hold: out=%h expected=%h", out, e);
    end
    #4 rst_n = 1'b1;
  endtask

  task automatic test_width8_sel();
    logic [W-1:0] e;
    in1 = 8'hA5; in2 = 8'h3C; sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      void'(exp_q.pop_front());
    end
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e) begin
        n_err++;
        $display("FAIL width8_sel[edge %0d]: out=%h expected=%h", i + 1, out, e);
      end
    end
    n_cmp++;
    if (out !== 8'h3C) begin
      n_err++;
      $display("FAIL width8_final: out=%h expected=%h", out, 8'h3C);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    for (int i = 0; i < 40; i++) begin
      in1 = W'($urandom_range(0, 255));
      in2 = W'($urandom_range(0, 255));
      sel = 1'($urandom_range(0, 1));
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: out=%h expected=%h", i, out, e);
      end
    end
  endtask

  // ---------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    m_s1  = 1'b0;
    m_s2  = 1'b0;
    rst_n = 1'b1;
    in1   = '0;
    in2   = '0;
    sel   = 1'b0;

    test_reset();
    test_static_in1();
    test_alternating();
    test_glitch();
    test_async_reset();
    test_width8_sel();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux.md
Name: mux

Overview:
- Registered 2:1 multiplexer.
- A combinational select stage produces internal node aux; aux is captured into the output register on each rising clk edge.
- Used as a clean, glitch-free selection point between two sources in clocked datapaths. Output changes only on clock edges.

Parameters:
- WIDTH, 1, bit width of in1, in2, aux and out.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into out while reset is asserted.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- in1  input  WIDTH  data source selected when effective select = 0.
- in2  input  WIDTH  data source selected when effective select = 1.
- sel  input  1  source select; 0 picks in1, 1 picks in2.
- out  output  WIDTH  registered mux result.

Behaviour:
- Internal net aux (WIDTH bits, named exactly aux, hierarchically visible for debug): aux = sel_eff ? in2 : in1, purely combinational.
- sel_eff = sel when the optional feature is off.
- out register:
  - on negedge rst_n: out <= RESET_VALUE immediately, independent of clk;
  - while rst_n = 0: out holds RESET_VALUE;
  - on posedge clk with rst_n = 1: out <= aux.
- Latency: one clk edge from in1/in2/sel to out. A change between edges is seen at the next rising edge only.
- Between edges, out is stable regardless of toggling on in1, in2 or sel; glitches on aux never reach out.
- Reset release: first rising edge after rst_n goes high loads aux normally. No extra dead cycle.
- Reset asserted mid-operation: out goes to RESET_VALUE asynchronously; the pending capture is discarded.
- X/Z on sel:
  - in simulation, aux follows the standard conditional operator (bitwise merge of in1/in2);
  - synthesis needs no special handling.
- Width: all data buses are WIDTH bits. No truncation or extension inside the block.
- No other state. No handshake.

Optional Feature:
- Macro MUX_SEL_SYNC_EN.
- Defined: sel passes through a 2-flop synchronizer (sel_s1, sel_s2) clocked by clk and reset to 0 by rst_n, with sel_eff = sel_s2.
  - Select-to-out latency becomes 3 edges; data-to-out latency stays 1 edge.
  - After reset, sel_eff = 0, so in1 is selected until the synchronizer fills.
- Not defined: sel_eff = sel directly. No synchronizer flops are present; select latency is 1 edge.

Test Plan:
1. Reset: in1=0, in2=1, sel=1, assert rst_n=0 between clock edges -> out=0 immediately and held over 3 edges; release -> out=1 at next posedge.
2. Static select in1: rst_n=1, sel=0, in1=0, in2=1 -> aux=0, out=0 after first posedge; swap to in1=1, in2=0 -> out=1 at next posedge.
3. Alternating select: clk period 20 ns with first posedge at 15 ns; sel toggles every 20 ns starting 0 at t=0; in1=0, in2=1 until t=100, then in1=1, in2=0 -> out follows aux sampled at each posedge:
   - t=15: out=0
   - t=35: out=1
   - t=55: out=0
   - t=75: out=1
   - t=95: out=0
   - t=115: out=0
4. Mid-cycle glitch: toggle sel 0->1->0 entirely between two posedges with in1=0, in2=1 -> aux pulses to 1; out stays 0.
5. Async reset mid-run: out=1, drop rst_n at 7 ns after a posedge -> out=0 within the same cycle, before the next clk edge.
6. WIDTH=8 with MUX_SEL_SYNC_EN defined: in1=8'hA5, in2=8'h3C, sel goes 0->1 -> out=8'hA5 for the next 2 posedges, out=8'h3C from the 3rd posedge on.
